// File: rtl/edge_router_switch_controller.sv
// ============================================================================
// Module   : edge_router_switch_controller
// Purpose  : CSR-controlled router select, switched only at video frame edges
// Revision : 1.0
// ============================================================================
`default_nettype none

module edge_router_switch_controller #(
    parameter int GUARD_CYCLES = 4,
    parameter int COUNT_WIDTH  = 16,
    parameter bit RESET_MODE   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        st_valid,
    input  logic        st_ready,
    input  logic        st_sop,
    input  logic        st_eop,
    output logic        stream_stall,
    output logic        out_port,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    localparam logic [7:0] c_GUARD_LAST = 8'(GUARD_CYCLES - 1);

    state_t                 r_state;
    logic                   r_ctrl_mode;
    logic                   r_irq_en;
    logic                   r_irq_flag;
    logic                   r_in_frame;
    logic                   r_out_port;
    logic [7:0]             r_guard_cnt;
    logic [COUNT_WIDTH-1:0] r_frame_count;
    logic [COUNT_WIDTH-1:0] r_switch_count;

    logic w_write;
    logic w_wr_ctrl;
    logic w_wr_status;
    logic w_beat;
    logic w_sop_beat;
    logic w_eop_beat;
    logic w_boundary;
    logic w_unused_wdata;

    assign w_write     = chipselect & ~write_n;
    assign w_wr_ctrl   = w_write & (address == 2'd0);
    assign w_wr_status = w_write & (address == 2'd1);

    assign w_beat      = st_valid & st_ready;
    assign w_sop_beat  = w_beat & st_sop;
    assign w_eop_beat  = w_beat & st_eop;
    // Between frames is a boundary unless a new frame starts this very beat.
    assign w_boundary  = w_eop_beat | (~r_in_frame & ~w_sop_beat);

    assign w_unused_wdata = &{1'b0, writedata[31:3]};

    // Control register and stream monitor.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl_mode   <= RESET_MODE;
            r_irq_en      <= 1'b0;
            r_in_frame    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl_mode <= writedata[0];
                r_irq_en    <= writedata[1];
            end
            if (w_eop_beat) begin
                r_in_frame    <= 1'b0;
                r_frame_count <= r_frame_count + 1'b1;
            end else if (w_sop_beat) begin
                r_in_frame <= 1'b1;
            end
        end
    end

    // Switch sequencer; owns the active select, switch count and done flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_out_port     <= RESET_MODE;
            r_switch_count <= '0;
            r_guard_cnt    <= '0;
            r_irq_flag     <= 1'b0;
        end else begin
            if (w_wr_status && writedata[2]) begin
                r_irq_flag <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_ctrl_mode != r_out_port) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_ctrl_mode == r_out_port) begin
                        r_state <= S_IDLE;
                    end else if (w_boundary) begin
                        r_out_port     <= r_ctrl_mode;
                        r_switch_count <= r_switch_count + 1'b1;
                        r_guard_cnt    <= '0;
                        r_state        <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (r_guard_cnt == c_GUARD_LAST) begin
                        r_irq_flag <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stream_stall = (r_state == S_GUARD);
    assign out_port     = r_out_port;
    assign irq          = r_irq_flag & r_irq_en;

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: readdata = {30'd0, r_irq_en, r_ctrl_mode};
            2'd1: readdata = {29'd0, r_irq_flag, (r_state == S_WAIT), r_out_port};
            2'd2: readdata = 32'(r_frame_count);
            2'd3: readdata = 32'(r_switch_count);
            default: readdata = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_edge_router_switch_controller.sv
// ============================================================================
// Module   : tb_edge_router_switch_controller
// Purpose  : Self-checking bench for edge_router_switch_controller
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_edge_router_switch_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        st_valid;
    logic        st_ready;
    logic        st_sop;
    logic        st_eop;
    logic        stream_stall;
    logic        out_port;
    logic        irq;

    always #5 clk = ~clk;

    edge_router_switch_controller #(
        .GUARD_CYCLES (4),
        .COUNT_WIDTH  (4),
        .RESET_MODE   (1'b0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_sop       (st_sop),
        .st_eop       (st_eop),
        .stream_stall (stream_stall),
        .out_port     (out_port),
        .irq          (irq)
    );

    typedef struct {
        string       name;
        logic [1:0]  addr;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t reset_tbl[4];
    sb_t  sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected value queued when the address is driven, popped once readdata settles.
    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        sb_t e;
        address = a;
        e.name  = name;
        e.exp   = exp;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        chk(e.name, readdata, e.exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic set_st(input logic v, input logic s, input logic e);
        st_valid = v;
        st_ready = v;
        st_sop   = s;
        st_eop   = e;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        steps(2);
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        for (int i = 0; i < 4; i++) rd_chk({tag, "_", reset_tbl[i].name}, reset_tbl[i].addr, reset_tbl[i].exp);
        chk({tag, "_out_port"}, out_port, 0);
        chk({tag, "_irq"}, irq, 0);
        chk({tag, "_stall"}, stream_stall, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_tbl[0] = '{"control", 2'd0, 32'h0};
        reset_tbl[1] = '{"status",  2'd1, 32'h0};
        reset_tbl[2] = '{"frames",  2'd2, 32'h0};
        reset_tbl[3] = '{"switches",2'd3, 32'h0};

        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        set_st(1'b0, 1'b0, 1'b0);
        do_reset();
        chk_reset_state("rst");

        // Idle stream: switch lands 3 cycles after the write cycle.
        wr(2'd0, 32'h3);
        chk("idle_n1_out", out_port, 0);
        step();
        chk("idle_n2_out", out_port, 0);
        rd_chk("idle_n2_pending", 2'd1, 32'h2);
        step();
        chk("idle_n3_out", out_port, 1);
        for (int i = 0; i < 4; i++) begin
            chk("idle_guard_stall", stream_stall, 1);
            step();
        end
        chk("idle_post_stall", stream_stall, 0);
        chk("idle_irq_set", irq, 1);
        rd_chk("idle_status", 2'd1, 32'h5);
        rd_chk("idle_switches", 2'd3, 32'h1);
        rd_chk("idle_control", 2'd0, 32'h3);
        wr(2'd1, 32'h4);
        chk("idle_irq_clr", irq, 0);
        rd_chk("idle_status_clr", 2'd1, 32'h1);

        // Reset during GUARD.
        do_reset();
        wr(2'd0, 32'h1);
        steps(2);
        chk("midguard_stall", stream_stall, 1);
        chk("midguard_out", out_port, 1);
        reset_n = 1'b0;
        step();
        chk_reset_state("grst");
        reset_n = 1'b1;
        step();

        // 10-beat frame, request at beat 3, switch after the eop beat.
        do_reset();
        for (int b = 0; b < 10; b++) begin
            set_st(1'b1, b == 0, b == 9);
            if (b >= 5) rd_chk("frame_pending", 2'd1, 32'h2);
            chk("frame_out_hold", out_port, 0);
            if (b == 3) wr(2'd0, 32'h1);
            else step();
        end
        set_st(1'b0, 1'b0, 1'b0);
        chk("frame_out_flip", out_port, 1);
        chk("frame_stall", stream_stall, 1);
        steps(4);
        rd_chk("frame_count", 2'd2, 32'h1);
        rd_chk("frame_switches", 2'd3, 32'h1);

        // Request withdrawn before eop.
        do_reset();
        for (int b = 0; b < 8; b++) begin
            set_st(1'b1, b == 0, b == 7);
            if (b == 3) rd_chk("wd_pending_on", 2'd1, 32'h2);
            if (b >= 5) rd_chk("wd_pending_off", 2'd1, 32'h0);
            chk("wd_out_hold", out_port, 0);
            if (b == 1)      wr(2'd0, 32'h1);
            else if (b == 3) wr(2'd0, 32'h0);
            else             step();
        end
        set_st(1'b0, 1'b0, 1'b0);
        step();
        chk("wd_out_final", out_port, 0);
        rd_chk("wd_switches", 2'd3, 32'h0);
        rd_chk("wd_status", 2'd1, 32'h0);

        // sop beat while waiting between frames blocks the switch until eop.
        do_reset();
        wr(2'd0, 32'h1);
        step();
        rd_chk("sopwait_pending", 2'd1, 32'h2);
        set_st(1'b1, 1'b1, 1'b0);
        step();
        chk("sopwait_no_switch", out_port, 0);
        set_st(1'b1, 1'b0, 1'b0);
        step();
        chk("sopwait_mid", out_port, 0);
        set_st(1'b1, 1'b0, 1'b1);
        step();
        set_st(1'b0, 1'b0, 1'b0);
        chk("sopwait_switch", out_port, 1);
        chk("sopwait_stall", stream_stall, 1);
        steps(4);
        // Single-beat frame must leave the monitor out of frame.
        set_st(1'b1, 1'b1, 1'b1);
        step();
        set_st(1'b0, 1'b0, 1'b0);
        step();
        wr(2'd0, 32'h0);
        step();
        chk("single_n2_out", out_port, 1);
        step();
        chk("single_n3_out", out_port, 0);
        rd_chk("single_frames", 2'd2, 32'h2);
        steps(4);

        // Counter wrap with a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_st(1'b1, 1'b1, 1'b1);
            step();
        end
        set_st(1'b0, 1'b0, 1'b0);
        rd_chk("wrap_frames", 2'd2, 32'h1);
        for (int i = 0; i < 16; i++) begin
            wr(2'd0, (i % 2 == 0) ? 32'h1 : 32'h0);
            steps(7);
            chk("wrap_toggle_out", out_port, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        rd_chk("wrap_switches", 2'd3, 32'h0);

        // Flag set and write-1-clear in the same cycle: set wins.
        wr(2'd0, 32'h1);
        steps(5);
        wr(2'd1, 32'h4);
        rd_chk("setclr_status", 2'd1, 32'h5);
        chk("setclr_irq_masked", irq, 0);
        wr(2'd1, 32'h4);
        rd_chk("setclr_cleared", 2'd1, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
